// File: rtl/i2c_scl_gen.sv
// I2C SCL timing generator: four-phase SCL period with a programmable divider and phase ticks.
// Optional slave clock stretching is enabled by defining I2C_SCL_STRETCH_EN.
module i2c_scl_gen #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             tick_fall,
    output logic             tick_data,
    output logic             tick_rise,
    output logic             tick_sample,
    output logic             stretch,
    output logic             busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOW_A  = 3'd1;
    localparam logic [2:0] S_LOW_B  = 3'd2;
    localparam logic [2:0] S_HIGH_A = 3'd3;
    localparam logic [2:0] S_HIGH_B = 3'd4;

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(8);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [CNT_W-1:0] period, pending, pend_next;
    logic [CNT_W-1:0] q, phase_len;
    logic             phase_end, hold, load_active;

    assign q         = {2'b00, period[CNT_W-1:2]};
    // LOW_B absorbs the remainder so the four phases always sum to exactly P.
    assign phase_len = (state == S_LOW_B) ? (period - q - {q[CNT_W-2:0], 1'b0}) : q;
    assign phase_end = (cnt == phase_len - CNT_W'(1));
    assign pend_next = !div_load ? pending : ((div_val < MIN_DIV) ? MIN_DIV : div_val);

`ifdef I2C_SCL_STRETCH_EN
    logic scl_meta, scl_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_sync <= scl_meta;
        end
    end

    assign hold = (state == S_HIGH_A) && phase_end && !scl_sync;
`else
    logic unused_scl_in;

    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
`endif

    assign stretch = hold;
    assign busy    = (state != S_IDLE);

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        next_cnt   = cnt + CNT_W'(1);
        if (!scl_en) begin
            next_state = S_IDLE;
            next_cnt   = '0;
        end else if (state == S_IDLE) begin
            next_state = S_HIGH_B;
            next_cnt   = '0;
        end else if (hold) begin
            next_cnt = cnt;
        end else if (phase_end) begin
            next_cnt = '0;
            case (state)
                S_LOW_A:  next_state = S_LOW_B;
                S_LOW_B:  next_state = S_HIGH_A;
                S_HIGH_A: next_state = S_HIGH_B;
                default:  next_state = S_LOW_A;
            endcase
        end
    end

    // The active period only changes between periods: while idle, or on entry to LOW_A.
    assign load_active = (state == S_IDLE) || ((next_state == S_LOW_A) && (state != S_LOW_A));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            period      <= DEF_DIV;
            pending     <= DEF_DIV;
            scl_oe      <= 1'b0;
            tick_fall   <= 1'b0;
            tick_data   <= 1'b0;
            tick_rise   <= 1'b0;
            tick_sample <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            pending     <= pend_next;
            if (load_active) begin
                period <= pend_next;
            end
            scl_oe      <= (next_state == S_LOW_A) || (next_state == S_LOW_B);
            tick_fall   <= (next_state == S_LOW_A)  && (state != S_LOW_A);
            tick_data   <= (next_state == S_LOW_B)  && (state != S_LOW_B);
            tick_rise   <= (next_state == S_HIGH_A) && (state != S_HIGH_A);
            tick_sample <= (next_state == S_HIGH_B) && (state != S_HIGH_B);
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Scoreboard bench for i2c_scl_gen: stimulus queues expected ticks, a monitor pops and compares them.
// Stretch scenario behaviour depends on I2C_SCL_STRETCH_EN.
module tb_i2c_scl_gen;

    localparam int CNT_W = 16;
    localparam logic [3:0] K_FALL   = 4'b1000;
    localparam logic [3:0] K_DATA   = 4'b0100;
    localparam logic [3:0] K_RISE   = 4'b0010;
    localparam logic [3:0] K_SAMPLE = 4'b0001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             scl_en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             scl_in = 1'b1;
    logic             scl_oe, tick_fall, tick_data, tick_rise, tick_sample, stretch, busy;

    i2c_scl_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(50)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_en      (scl_en),
        .div_load    (div_load),
        .div_val     (div_val),
        .scl_in      (scl_in),
        .scl_oe      (scl_oe),
        .tick_fall   (tick_fall),
        .tick_data   (tick_data),
        .tick_rise   (tick_rise),
        .tick_sample (tick_sample),
        .stretch     (stretch),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } evt_t;
    evt_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] k);
        evt_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    task automatic push_period(input int f, input int d, input int r, input int s);
        push(f, K_FALL);
        push(f + d, K_DATA);
        push(f + r, K_RISE);
        push(f + s, K_SAMPLE);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: every tick the DUT presents must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [3:0] k;
        evt_t       e;
        k = {tick_fall, tick_data, tick_rise, tick_sample};
        if (k !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 64'(k), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("evt_cyc", 64'(cyc), 64'(e.cyc));
                check("evt_kind", 64'(k), 64'(e.kind));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int c0, f1, f2, f3, f4, f5, f6, f7, c1, c2, fa, c3, c4, fs;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({scl_oe, busy, stretch, tick_fall, tick_data, tick_rise, tick_sample}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Default 50-cycle period, mid-LOW_B load of 25, then load of 3 coinciding with LOW_A entry.
        c0 = cyc;
        f1 = c0 + 13;
        f2 = f1 + 50;
        f3 = f2 + 50;
        f4 = f3 + 25;
        f5 = f4 + 25;
        f6 = f5 + 8;
        f7 = f6 + 8;
        push(c0 + 1, K_SAMPLE);
        push_period(f1, 12, 26, 38);
        push_period(f2, 12, 26, 38);
        push_period(f3, 6, 13, 19);
        push_period(f4, 6, 13, 19);
        push_period(f5, 2, 4, 6);
        push_period(f6, 2, 4, 6);
        push(f7, K_FALL);
        push(f7 + 2, K_DATA);
        push(f7 + 4, K_RISE);
        scl_en = 1'b1;
        @(negedge clk);
        check("fast_start_busy", 64'(busy), 64'd1);
        wait_until(f1);
        check("low_a_oe", 64'(scl_oe), 64'd1);
        wait_until(f1 + 26);
        check("high_a_oe", 64'(scl_oe), 64'd0);
        wait_until(f2 + 14);
        div_load = 1'b1;
        div_val  = 16'd25;
        @(negedge clk);
        div_load = 1'b0;
        wait_until(f5 - 1);
        div_load = 1'b1;
        div_val  = 16'd3;
        @(negedge clk);
        div_load = 1'b0;

        // Abort during HIGH_A, fast restart, abort during LOW_A.
        wait_until(f7 + 4);
        scl_en = 1'b0;
        @(negedge clk);
        check("abort_high_a", 64'({busy, scl_oe}), 64'd0);
        c1 = f7 + 8;
        wait_until(c1);
        push(c1 + 1, K_SAMPLE);
        push(c1 + 3, K_FALL);
        scl_en = 1'b1;
        wait_until(c1 + 3);
        check("oe_before_abort", 64'(scl_oe), 64'd1);
        scl_en = 1'b0;
        @(negedge clk);
        check("abort_low_a", 64'({busy, scl_oe}), 64'd0);

        // Asynchronous reset in LOW_B with a pending value of 20 that must be discarded.
        c2 = c1 + 6;
        wait_until(c2);
        fa = c2 + 3;
        push(c2 + 1, K_SAMPLE);
        push(fa, K_FALL);
        push(fa + 2, K_DATA);
        scl_en = 1'b1;
        wait_until(fa);
        div_load = 1'b1;
        div_val  = 16'd20;
        @(negedge clk);
        div_load = 1'b0;
        wait_until(fa + 2);
        #2;
        rst_n  = 1'b0;
        scl_en = 1'b0;
        #1;
        check("async_reset", 64'({scl_oe, busy, stretch, tick_fall, tick_data, tick_rise, tick_sample}), 64'd0);
        wait_until(fa + 5);
        rst_n = 1'b1;
        c3 = fa + 8;
        wait_until(c3);
        push(c3 + 1, K_SAMPLE);
        push_period(c3 + 13, 12, 26, 38);
        push(c3 + 63, K_FALL);
        scl_en = 1'b1;
        wait_until(c3 + 63);
        scl_en = 1'b0;

        // P=40 with scl_in held low for 30 cycles from tick_rise.
        wait_until(c3 + 66);
        div_load = 1'b1;
        div_val  = 16'd40;
        @(negedge clk);
        div_load = 1'b0;
        c4 = c3 + 70;
        wait_until(c4);
        fs = c4 + 11;
        push(c4 + 1, K_SAMPLE);
        push(fs, K_FALL);
        push(fs + 10, K_DATA);
        push(fs + 20, K_RISE);
        scl_en = 1'b1;
        wait_until(fs + 20);
        scl_in = 1'b0;
`ifdef I2C_SCL_STRETCH_EN
        push(fs + 53, K_SAMPLE);
        push(fs + 63, K_FALL);
        wait_until(fs + 28);
        check("stretch_before_last", 64'(stretch), 64'd0);
        wait_until(fs + 29);
        check("stretch_assert", 64'(stretch), 64'd1);
        wait_until(fs + 50);
        scl_in = 1'b1;
        wait_until(fs + 51);
        check("stretch_held", 64'(stretch), 64'd1);
        wait_until(fs + 52);
        check("stretch_release", 64'(stretch), 64'd0);
        wait_until(fs + 63);
`else
        push(fs + 30, K_SAMPLE);
        push(fs + 40, K_FALL);
        wait_until(fs + 29);
        check("no_stretch", 64'(stretch), 64'd0);
        wait_until(fs + 40);
        scl_in = 1'b1;
`endif
        scl_en = 1'b0;
        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
